// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared memory definitions: FSM encoding, latency default, counter width
package mem_defs;

  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_WIDTH       = 4;
  localparam int WORD_WIDTH      = 16;

  // The CPU stall logic decodes these encodings directly.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Counter preload for a request that spans more than one cycle.
  function automatic logic [CNT_WIDTH-1:0] latency_preload(input int lat);
    return CNT_WIDTH'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with synchronous write and combinational read
module mem_array
  import mem_defs::*;
#(
  parameter int IDX_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [WORD_WIDTH-1:0] rd_data
);

  // Contents are deliberately not reset so they survive a CPU reset.
  logic [WORD_WIDTH-1:0] words [2**IDX_WIDTH];

  // Commit one word per write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_data = words[rd_idx];

endmodule

// File: rtl/multicycle_memory.sv
// rtl/multicycle_memory.sv - fixed-latency memory with a request FSM in front of mem_array
module multicycle_memory
  import mem_defs::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 1;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [IDX_WIDTH-1:0]  cap_idx;
  logic                  cap_wr;
  logic [WORD_WIDTH-1:0] cap_data;

  logic                  accept;
  logic                  finish_wr;
  logic                  finish_rd;
  logic                  mem_we;
  logic [IDX_WIDTH-1:0]  mem_wr_idx;
  logic [IDX_WIDTH-1:0]  mem_rd_idx;
  logic [WORD_WIDTH-1:0] mem_wr_data;
  logic [WORD_WIDTH-1:0] mem_rd_data;

  // Byte-lane bit has no meaning for 16-bit words.
  logic addr_unused;
  assign addr_unused = addr[0];

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: stay in WAIT until the counter shows the final busy cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (LATENCY > 1)) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and storage strobes; single-cycle latency bypasses the capture registers.
  always_comb begin
    busy   = (state == WAIT);
    accept = rst_n && enable && (state == IDLE);
    if (LATENCY == 1) begin
      finish_wr   = accept && wr;
      finish_rd   = accept && !wr;
      mem_wr_idx  = addr[ADDR_WIDTH-1:1];
      mem_rd_idx  = addr[ADDR_WIDTH-1:1];
      mem_wr_data = data_in;
    end else begin
      finish_wr   = rst_n && (state == WAIT) && (cnt == 4'd1) && cap_wr;
      finish_rd   = rst_n && (state == WAIT) && (cnt == 4'd1) && !cap_wr;
      mem_wr_idx  = cap_idx;
      mem_rd_idx  = cap_idx;
      mem_wr_data = cap_data;
    end
    mem_we = finish_wr;
  end

  // Counter, request capture and read-data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      cap_idx    <= '0;
      cap_wr     <= 1'b0;
      cap_data   <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      data_valid <= finish_rd;
      if (finish_rd) begin
        data_out <= mem_rd_data;
      end
      if (accept) begin
        cap_idx  <= addr[ADDR_WIDTH-1:1];
        cap_wr   <= wr;
        cap_data <= data_in;
      end
      if (accept && (LATENCY > 1)) begin
        cnt <= latency_preload(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  mem_array #(
    .IDX_WIDTH(IDX_WIDTH)
  ) u_mem_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_idx  (mem_wr_idx),
    .wr_data (mem_wr_data),
    .rd_idx  (mem_rd_idx),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_multicycle_memory.sv
// tb/tb_multicycle_memory.sv - directed bench for multicycle_memory at LATENCY 4 and 1
module tb_multicycle_memory;

  logic        clk;
  logic        t_rstn [2];
  logic        t_en   [2];
  logic        t_wr   [2];
  logic [15:0] t_addr [2];
  logic [15:0] t_din  [2];
  logic [15:0] t_dout [2];
  logic        t_dv   [2];
  logic        t_busy [2];

  int total = 0;
  int bad   = 0;

  multicycle_memory #(.LATENCY(4), .ADDR_WIDTH(16)) dut4 (
    .clk(clk), .rst_n(t_rstn[0]), .enable(t_en[0]), .wr(t_wr[0]), .addr(t_addr[0]),
    .data_in(t_din[0]), .data_out(t_dout[0]), .data_valid(t_dv[0]), .busy(t_busy[0])
  );

  multicycle_memory #(.LATENCY(1), .ADDR_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(t_rstn[1]), .enable(t_en[1]), .wr(t_wr[1]), .addr(t_addr[1]),
    .data_in(t_din[1]), .data_out(t_dout[1]), .data_valid(t_dv[1]), .busy(t_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted request completes LATENCY cycles later.
  bit          m_valid [2];
  bit          m_fly   [2];
  bit          m_wr    [2];
  bit          m_busy  [2];
  bit          m_dv    [2];
  bit          m_known [2];
  int          m_age   [2];
  logic [14:0] m_idx   [2];
  logic [15:0] m_data  [2];
  logic [15:0] m_dout  [2];
  logic [15:0] mmem    [int];

  task automatic finish_req(input int d);
    int key;
    key = d * 65536 + int'(m_idx[d]);
    m_fly[d] = 0;
    if (m_wr[d]) begin
      mmem[key] = m_data[d];
    end else begin
      m_dv[d] = 1;
      if (mmem.exists(key)) begin
        m_dout[d]  = mmem[key];
        m_known[d] = 1;
      end else begin
        m_known[d] = 0;
      end
    end
  endtask

  task automatic model_step(input int d, input int lat);
    bit acc;
    if (!t_rstn[d]) begin
      m_valid[d] = 1; m_fly[d] = 0; m_busy[d] = 0; m_dv[d] = 0;
      m_dout[d] = 16'h0000; m_known[d] = 1;
      return;
    end
    acc = t_en[d] && !m_busy[d];
    m_dv[d] = 0;
    if (m_fly[d]) begin
      m_age[d]++;
      if (m_age[d] == lat) finish_req(d);
    end
    if (acc) begin
      m_fly[d] = 1; m_age[d] = 1; m_wr[d] = t_wr[d];
      m_idx[d] = t_addr[d][15:1]; m_data[d] = t_din[d];
      if (lat == 1) finish_req(d);
    end
    m_busy[d] = m_fly[d];
  endtask

  always @(posedge clk) begin
    model_step(0, 4);
    model_step(1, 1);
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d]) begin
        chk($sformatf("model_busy%0d", d), {15'b0, t_busy[d]}, {15'b0, m_busy[d]});
        chk($sformatf("model_dv%0d", d), {15'b0, t_dv[d]}, {15'b0, m_dv[d]});
        if (m_known[d]) chk($sformatf("model_dout%0d", d), t_dout[d], m_dout[d]);
      end
    end
  end

  task automatic drive(input int d, input logic e, input logic w, input logic [15:0] a, input logic [15:0] di);
    t_en[d] = e; t_wr[d] = w; t_addr[d] = a; t_din[d] = di;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Issue one request and return in its completion cycle C(lat).
  task automatic req(input int d, input int lat, input logic w, input logic [15:0] a, input logic [15:0] di);
    drive(d, 1'b1, w, a, di);
    step(1);
    drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
    if (lat > 1) step(lat - 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      t_rstn[d] = 1'b0;
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    step(2);
    chk("rst_busy", {15'b0, t_busy[0]}, 16'h0);
    chk("rst_dv", {15'b0, t_dv[0]}, 16'h0);
    chk("rst_dout", t_dout[0], 16'h0000);
    t_rstn[0] = 1'b1;
    t_rstn[1] = 1'b1;

    req(0, 4, 1'b1, 16'h0020, 16'h1111);
    req(0, 4, 1'b1, 16'h0030, 16'h3333);
    req(0, 4, 1'b1, 16'h0000, 16'h0F0F);

    // write 0x1234 to 0x0010, then read it back in C4
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
    step(1);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      chk("wr_busy", {15'b0, t_busy[0]}, 16'h1);
      chk("wr_dv", {15'b0, t_dv[0]}, 16'h0);
      step(1);
    end
    chk("wr_c4_busy", {15'b0, t_busy[0]}, 16'h0);
    chk("wr_c4_dv", {15'b0, t_dv[0]}, 16'h0);
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    step(1);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(3);
    chk("rd_c8_dv", {15'b0, t_dv[0]}, 16'h1);
    chk("rd_c8_dout", t_dout[0], 16'h1234);
    step(1);
    chk("rd_c9_dv", {15'b0, t_dv[0]}, 16'h0);
    chk("rd_c9_hold", t_dout[0], 16'h1234);

    // write request during a read is ignored
    drive(0, 1'b1, 1'b0, 16'h0020, 16'h0);
    step(1);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1);
    drive(0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
    step(1);
    chk("ign_c3_dv", {15'b0, t_dv[0]}, 16'h0);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1);
    chk("ign_c4_dv", {15'b0, t_dv[0]}, 16'h1);
    chk("ign_c4_dout", t_dout[0], 16'h1111);
    step(1);
    chk("ign_c5_dv", {15'b0, t_dv[0]}, 16'h0);
    req(0, 4, 1'b0, 16'h0020, 16'h0);
    chk("ign_unchanged", t_dout[0], 16'h1111);

    // reset in the middle of a write aborts it
    drive(0, 1'b1, 1'b1, 16'h0030, 16'hAAAA);
    step(1);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1);
    t_rstn[0] = 1'b0;
    step(1);
    chk("midrst_busy", {15'b0, t_busy[0]}, 16'h0);
    chk("midrst_dv", {15'b0, t_dv[0]}, 16'h0);
    chk("midrst_dout", t_dout[0], 16'h0000);
    t_rstn[0] = 1'b1;
    step(1);
    req(0, 4, 1'b0, 16'h0030, 16'h0);
    chk("midrst_kept", t_dout[0], 16'h3333);

    // aliasing of the byte-lane bit at the top of the space
    req(0, 4, 1'b1, 16'hFFFF, 16'h5A5A);
    req(0, 4, 1'b0, 16'hFFFE, 16'h0);
    chk("alias_dout", t_dout[0], 16'h5A5A);
    req(0, 4, 1'b0, 16'h0000, 16'h0);
    chk("alias_zero", t_dout[0], 16'h0F0F);

    // back-to-back reads: second one issued in the first one's data_valid cycle
    req(0, 4, 1'b0, 16'h0010, 16'h0);
    chk("b2b_first", t_dout[0], 16'h1234);
    drive(0, 1'b1, 1'b0, 16'h0030, 16'h0);
    step(1);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      chk("b2b_gap_dv", {15'b0, t_dv[0]}, 16'h0);
      step(1);
    end
    chk("b2b_dv", {15'b0, t_dv[0]}, 16'h1);
    chk("b2b_dout", t_dout[0], 16'h3333);

    // read issued in the completion cycle of a write to the same word
    req(0, 4, 1'b1, 16'h0040, 16'h7777);
    req(0, 4, 1'b0, 16'h0040, 16'h0);
    chk("raw_dout", t_dout[0], 16'h7777);
    step(2);

    // single-cycle latency
    req(1, 1, 1'b1, 16'h0002, 16'h2222);
    req(1, 1, 1'b1, 16'h0004, 16'h4444);
    drive(1, 1'b1, 1'b0, 16'h0002, 16'h0);
    step(1);
    chk("l1_c1_busy", {15'b0, t_busy[1]}, 16'h0);
    chk("l1_c1_dv", {15'b0, t_dv[1]}, 16'h1);
    chk("l1_c1_dout", t_dout[1], 16'h2222);
    drive(1, 1'b1, 1'b0, 16'h0004, 16'h0);
    step(1);
    chk("l1_c2_dv", {15'b0, t_dv[1]}, 16'h1);
    chk("l1_c2_dout", t_dout[1], 16'h4444);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1);
    chk("l1_c3_dv", {15'b0, t_dv[1]}, 16'h0);
    chk("l1_c3_hold", t_dout[1], 16'h4444);
    drive(1, 1'b1, 1'b1, 16'h0006, 16'h6666);
    step(1);
    drive(1, 1'b1, 1'b0, 16'h0006, 16'h0);
    step(1);
    chk("l1_raw", t_dout[1], 16'h6666);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
